ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Shares the single system RAM port between 8088 CPU memory cycles (MEMR_N/MEMW_N from the bus arbiter) and video fetch requests from the gate array. It drives CPU RDY low while a CPU access waits for or occupies the RAM, runs fixed-length RAM cycles, and returns fetched bytes to the video requester with a one-cycle acknowledge. It sits inside CHIPSET between the bus command decode and the RAM interface.

## Interface
- RAM_ADDR_WIDTH, 17, RAM address bits; CPU addresses below 2**RAM_ADDR_WIDTH hit RAM.
- RAM_ACCESS_CYCLES, 2, clocks the RAM strobe is held low per access (legal range 1..15).
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cpu_clock_negedge  in  1  one-clock strobe at each CPU clock falling edge.
- cpu_address  in  20  latched CPU address.
- cpu_data_in  in  8  CPU write data.
- cpu_memr_n  in  1  CPU memory read command, active low.
- cpu_memw_n  in  1  CPU memory write command, active low.
- cpu_data_out  out  8  read data for the CPU, held until next CPU read completes.
- rdy  out  1  CPU ready; 0 inserts wait states.
- video_request  in  1  level request; held high until video_ack.
- video_address  in  RAM_ADDR_WIDTH  video fetch address, stable while video_request high.
- video_ack  out  1  one-clock pulse; video_data valid in the same cycle.
- video_data  out  8  fetched byte.
- ram_address  out  RAM_ADDR_WIDTH  RAM address.
- ram_data_out  out  8  RAM write data.
- ram_data_in  in  8  RAM read data.
- ram_read_n  out  1  RAM read strobe, active low.
- ram_write_n  out  1  RAM write strobe, active low.

## Operation
- CPU command: cpu_memr_n or cpu_memw_n low with cpu_address below RAM limit. Both low: treated as read, no write strobe. Out-of-range commands ignored; rdy untouched.
- New CPU command (command active, not pending, not served): cpu_pending=1, rdy=0 on next clock.
- States: IDLE, ACCESS, RECOVER.
- IDLE: pick requester, register ram_address/ram_data_out/direction, go ACCESS. Strict priority: video before CPU. Nothing pending: stay.
- ACCESS: selected strobe low for RAM_ACCESS_CYCLES clocks (down-counter); on final cycle sample ram_data_in; go RECOVER.
- RECOVER: both strobes high one clock. Video: video_ack=1, video_data=sample. CPU: cpu_data_out=sample (reads only), cpu_pending=0, cpu_served=1, release pending.
- rdy release: rdy returns to 1 on the first cpu_clock_negedge strobe at or after RECOVER.
- cpu_served cleared when both commands inactive; blocks re-serving the same bus cycle.
- Reset mid-access: state IDLE, strobes high, pending/served cleared, request dropped; no ack.

## Timing
- Reset values: rdy=1, video_ack=0, video_data=0, cpu_data_out=0, ram_address=0, ram_data_out=0, ram_read_n=1, ram_write_n=1; state IDLE.
- Grant seen in IDLE at cycle N: strobe low N+1..N+RAM_ACCESS_CYCLES, RECOVER at N+RAM_ACCESS_CYCLES+1, IDLE at N+RAM_ACCESS_CYCLES+2.
- Back-to-back: slot period RAM_ACCESS_CYCLES+2 clocks.
- ram_address/ram_data_out stable for whole ACCESS; never change while a strobe is low.
- video_request still high after video_ack is a new request.
- Worst CPU wait, strict mode: unbounded under continuous video load.

## Configuration
- KFPCJR_FAIR_ARBITRATION_EN defined: round-robin; after a video grant a pending CPU request wins the next IDLE decision, and vice versa. CPU wait bounded to two slots plus rdy sync.
- Undefined: strict video priority as above.

## Test plan
- CPU read 0x01234, RAM returns 0xA5, RAM_ACCESS_CYCLES=2 -> ram_read_n low 2 clocks, cpu_data_out=0xA5, rdy 1 at first negedge strobe after RECOVER.
- CPU write 0x00010 data 0x3C -> ram_write_n low 2 clocks, ram_data_out=0x3C, ram_read_n stays 1.
- CPU read at 0x20000 -> no RAM strobe, rdy stays 1.
- Video and CPU request same cycle, strict -> video served first, video_ack then CPU; fair mode with continuous video -> CPU served on second slot.
- CPU command held 20 clocks after completion -> exactly one RAM access.
- reset asserted during ACCESS -> next clock strobes 1, rdy=1, no video_ack; fresh request served normally.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//
// Shares the single system RAM port between 8088 CPU memory cycles and
// video fetch requests from the gate array. Each RAM access is a fixed-length
// slot: one IDLE decision clock, RAM_ACCESS_CYCLES clocks with a strobe low,
// and one RECOVER clock with both strobes high. A CPU access holds rdy low
// from the clock after the command is seen until the first CPU-clock falling
// edge strobe at or after RECOVER. Video fetches are acknowledged with a
// one-clock video_ack pulse during RECOVER, with video_data valid alongside.
//
// Build option:
//   KFPCJR_FAIR_ARBITRATION_EN  defined   -> round-robin between video and CPU
//                               undefined -> strict video-before-CPU priority
//
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   cpu_clock_negedge        one-clock strobe per CPU clock falling edge
//   cpu_address/cpu_data_in  latched CPU address / write data
//   cpu_memr_n/cpu_memw_n    CPU memory read / write commands (active low)
//   cpu_data_out             last CPU read byte
//   rdy                      CPU ready (0 inserts wait states)
//   video_request/address    level fetch request and its address
//   video_ack/video_data     one-clock acknowledge and fetched byte
//   ram_address/ram_data_out RAM address and write data
//   ram_data_in              RAM read data
//   ram_read_n/ram_write_n   RAM strobes (active low)

module ram_access_arbiter #(
  parameter int RAM_ADDR_WIDTH    = 17,
  parameter int RAM_ACCESS_CYCLES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cpu_clock_negedge,
  input  logic [19:0]               cpu_address,
  input  logic [7:0]                cpu_data_in,
  input  logic                      cpu_memr_n,
  input  logic                      cpu_memw_n,
  output logic [7:0]                cpu_data_out,
  output logic                      rdy,
  input  logic                      video_request,
  input  logic [RAM_ADDR_WIDTH-1:0] video_address,
  output logic                      video_ack,
  output logic [7:0]                video_data,
  output logic [RAM_ADDR_WIDTH-1:0] ram_address,
  output logic [7:0]                ram_data_out,
  input  logic [7:0]                ram_data_in,
  output logic                      ram_read_n,
  output logic                      ram_write_n
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  // The counter is loaded with cycles-1 so it reaches zero on the final
  // strobe-low clock.
  localparam logic [3:0] CNT_LOAD = 4'(RAM_ACCESS_CYCLES - 1);

  logic [1:0]                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      sel_video_q, sel_video_d;
  logic                      sel_write_q, sel_write_d;
  logic                      cpu_pending_q, cpu_pending_d;
  logic                      cpu_served_q, cpu_served_d;
  logic                      rdy_q, rdy_d;
  logic                      rdy_release_q, rdy_release_d;
  logic                      video_ack_q, video_ack_d;
  logic [7:0]                video_data_q, video_data_d;
  logic [7:0]                cpu_data_q, cpu_data_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [7:0]                ram_data_out_q, ram_data_out_d;
  logic                      ram_read_n_q, ram_read_n_d;
  logic                      ram_write_n_q, ram_write_n_d;

  logic cpu_cmd_any;
  logic cpu_in_range;
  logic cpu_cmd;
  logic cpu_wr_only;
  logic grant_video;
  logic grant_cpu;

  assign cpu_cmd_any  = ~cpu_memr_n | ~cpu_memw_n;
  assign cpu_in_range = (cpu_address >> RAM_ADDR_WIDTH) == 20'd0;
  assign cpu_cmd      = cpu_cmd_any & cpu_in_range;
  // A read strobe wins when both commands are asserted together.
  assign cpu_wr_only  = cpu_memr_n & ~cpu_memw_n;

`ifdef KFPCJR_FAIR_ARBITRATION_EN
  logic last_video_q, last_video_d;
  // Video loses a tie only when the previous grant also went to video.
  assign grant_video = video_request & ~(cpu_pending_q & last_video_q);
`else
  assign grant_video = video_request;
`endif
  assign grant_cpu = cpu_pending_q & ~grant_video;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_video_d    = sel_video_q;
    sel_write_d    = sel_write_q;
    cpu_pending_d  = cpu_pending_q;
    cpu_served_d   = cpu_served_q;
    rdy_d          = rdy_q;
    rdy_release_d  = rdy_release_q;
    video_ack_d    = 1'b0;
    video_data_d   = video_data_q;
    cpu_data_d     = cpu_data_q;
    ram_address_d  = ram_address_q;
    ram_data_out_d = ram_data_out_q;
    ram_read_n_d   = ram_read_n_q;
    ram_write_n_d  = ram_write_n_q;
`ifdef KFPCJR_FAIR_ARBITRATION_EN
    last_video_d   = last_video_q;
`endif

    // The served flag stays set until the CPU ends its bus cycle, so a
    // command held over several clocks is never run twice.
    if (!cpu_cmd_any) cpu_served_d = 1'b0;

    if (rdy_release_q && cpu_clock_negedge) begin
      rdy_d         = 1'b1;
      rdy_release_d = 1'b0;
    end

    if (cpu_cmd && !cpu_pending_q && !cpu_served_q) begin
      cpu_pending_d = 1'b1;
      rdy_d         = 1'b0;
      rdy_release_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_video || grant_cpu) begin
          state_d     = ST_ACCESS;
          cnt_d       = CNT_LOAD;
          sel_video_d = grant_video;
`ifdef KFPCJR_FAIR_ARBITRATION_EN
          last_video_d = grant_video;
`endif
          if (grant_video) begin
            ram_address_d = video_address;
            sel_write_d   = 1'b0;
            ram_read_n_d  = 1'b0;
          end else begin
            ram_address_d  = cpu_address[RAM_ADDR_WIDTH-1:0];
            ram_data_out_d = cpu_data_in;
            sel_write_d    = cpu_wr_only;
            ram_read_n_d   = cpu_wr_only;
            ram_write_n_d  = ~cpu_wr_only;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d       = ST_RECOVER;
          ram_read_n_d  = 1'b1;
          ram_write_n_d = 1'b1;
          if (sel_video_q) begin
            video_ack_d  = 1'b1;
            video_data_d = ram_data_in;
          end else begin
            if (!sel_write_q) cpu_data_d = ram_data_in;
            cpu_pending_d = 1'b0;
            cpu_served_d  = 1'b1;
            rdy_release_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RECOVER: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      sel_video_q    <= 1'b0;
      sel_write_q    <= 1'b0;
      cpu_pending_q  <= 1'b0;
      cpu_served_q   <= 1'b0;
      rdy_q          <= 1'b1;
      rdy_release_q  <= 1'b0;
      video_ack_q    <= 1'b0;
      video_data_q   <= 8'd0;
      cpu_data_q     <= 8'd0;
      ram_address_q  <= '0;
      ram_data_out_q <= 8'd0;
      ram_read_n_q   <= 1'b1;
      ram_write_n_q  <= 1'b1;
`ifdef KFPCJR_FAIR_ARBITRATION_EN
      last_video_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_video_q    <= sel_video_d;
      sel_write_q    <= sel_write_d;
      cpu_pending_q  <= cpu_pending_d;
      cpu_served_q   <= cpu_served_d;
      rdy_q          <= rdy_d;
      rdy_release_q  <= rdy_release_d;
      video_ack_q    <= video_ack_d;
      video_data_q   <= video_data_d;
      cpu_data_q     <= cpu_data_d;
      ram_address_q  <= ram_address_d;
      ram_data_out_q <= ram_data_out_d;
      ram_read_n_q   <= ram_read_n_d;
      ram_write_n_q  <= ram_write_n_d;
`ifdef KFPCJR_FAIR_ARBITRATION_EN
      last_video_q   <= last_video_d;
`endif
    end
  end

  assign cpu_data_out = cpu_data_q;
  assign rdy          = rdy_q;
  assign video_ack    = video_ack_q;
  assign video_data   = video_data_q;
  assign ram_address  = ram_address_q;
  assign ram_data_out = ram_data_out_q;
  assign ram_read_n   = ram_read_n_q;
  assign ram_write_n  = ram_write_n_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
module tb_ram_access_arbiter;
  localparam int AW  = 17;
  localparam int RAC = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_clock_negedge;
  logic [19:0]   cpu_address;
  logic [7:0]    cpu_data_in;
  logic          cpu_memr_n, cpu_memw_n;
  logic [7:0]    cpu_data_out;
  logic          rdy;
  logic          video_request;
  logic [AW-1:0] video_address;
  logic          video_ack;
  logic [7:0]    video_data;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data_out;
  logic [7:0]    ram_data_in;
  logic          ram_read_n, ram_write_n;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } acc_t;

  acc_t       exp_acc[$];
  logic [7:0] exp_vid[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int cyc = 0;
  int recover_cyc = 0;
  logic [7:0] mem [0:(1<<AW)-1];

  assign ram_data_in = mem[ram_address];

  ram_access_arbiter #(.RAM_ADDR_WIDTH(AW), .RAM_ACCESS_CYCLES(RAC)) dut (
    .clock(clock), .reset(reset), .cpu_clock_negedge(cpu_clock_negedge),
    .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_memr_n(cpu_memr_n), .cpu_memw_n(cpu_memw_n),
    .cpu_data_out(cpu_data_out), .rdy(rdy),
    .video_request(video_request), .video_address(video_address),
    .video_ack(video_ack), .video_data(video_data),
    .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_data_in(ram_data_in), .ram_read_n(ram_read_n), .ram_write_n(ram_write_n)
  );

  initial forever #5 clock = ~clock;

  // Cycle counter and CPU falling-edge strobe every third system clock.
  initial begin
    cpu_clock_negedge = 1'b0;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      cpu_clock_negedge = (cyc % 3 == 0);
    end
  end

  // Scoreboard monitor: RAM accesses and video acknowledges.
  initial begin : mon
    bit on;
    int len;
    logic [AW-1:0] a0;
    logic [7:0] d0;
    acc_t e;
    logic [7:0] ev;
    on = 0; len = 0;
    forever begin
      @(negedge clock);
      if (reset) on = 0;
      else begin
        if ((ram_read_n === 1'b0 || ram_write_n === 1'b0) && !on) begin
          n_acc++; on = 1; len = 1; a0 = ram_address; d0 = ram_data_out;
          n_cmp++;
          if (exp_acc.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_access got addr=%h rd_n=%b wr_n=%b required none", ram_address, ram_read_n, ram_write_n);
          end else begin
            e = exp_acc.pop_front();
            if (ram_address !== e.addr || ram_read_n !== e.wr || ram_write_n !== ~e.wr ||
                (e.wr && ram_data_out !== e.wdata)) begin
              n_bad++;
              $display("FAIL access got addr=%h rd_n=%b wr_n=%b wd=%h required addr=%h wr=%b wd=%h",
                       ram_address, ram_read_n, ram_write_n, ram_data_out, e.addr, e.wr, e.wdata);
            end
          end
          if (ram_write_n === 1'b0) mem[ram_address] = ram_data_out;
        end else if ((ram_read_n === 1'b0 || ram_write_n === 1'b0) && on) begin
          len++;
          n_cmp++;
          if (ram_address !== a0 || ram_data_out !== d0) begin
            n_bad++;
            $display("FAIL addr_stable got %h/%h required %h/%h", ram_address, ram_data_out, a0, d0);
          end
        end else if (on) begin
          on = 0; recover_cyc = cyc;
          n_cmp++;
          if (len != RAC) begin
            n_bad++;
            $display("FAIL strobe_len got %0d required %0d", len, RAC);
          end
        end
        if (video_ack === 1'b1) begin
          n_cmp++;
          if (exp_vid.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_ack got data=%h required no ack", video_data);
          end else begin
            ev = exp_vid.pop_front();
            if (video_data !== ev) begin
              n_bad++;
              $display("FAIL video_data got %h required %h", video_data, ev);
            end
          end
        end
      end
    end
  end

  task automatic wait_rdy(input logic v, input int budget, output bit ok, output int at);
    ok = 0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (rdy === v) begin ok = 1; at = cyc; break; end
    end
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (ram_read_n === 1'b0 || ram_write_n === 1'b0) begin ok = 1; break; end
    end
  endtask

  task automatic video_run(input int n, input logic [AW-1:0] base);
    int got = 0;
    int t = 0;
    video_address = base;
    video_request = 1'b1;
    while (got < n && t < 400) begin
      @(negedge clock);
      t++;
      if (video_ack === 1'b1) begin
        got++;
        if (got < n) video_address = base + AW'(got);
        else video_request = 1'b0;
      end
    end
    n_cmp++;
    if (got != n) begin
      n_bad++;
      $display("FAIL video_run_acks got %0d required %0d", got, n);
      video_request = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b required 1", rdy); end
    n_cmp++; if (video_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b required 0", video_ack); end
    n_cmp++; if (video_data !== 8'h00) begin n_bad++; $display("FAIL reset_vdata got %h required 00", video_data); end
    n_cmp++; if (cpu_data_out !== 8'h00) begin n_bad++; $display("FAIL reset_cdata got %h required 00", cpu_data_out); end
    n_cmp++; if (ram_address !== '0) begin n_bad++; $display("FAIL reset_addr got %h required 0", ram_address); end
    n_cmp++; if (ram_data_out !== 8'h00) begin n_bad++; $display("FAIL reset_wdata got %h required 00", ram_data_out); end
    n_cmp++; if (ram_read_n !== 1'b1 || ram_write_n !== 1'b1) begin n_bad++; $display("FAIL reset_strobes got %b%b required 11", ram_read_n, ram_write_n); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (rdy !== 1'b1 || ram_read_n !== 1'b1) begin n_bad++; $display("FAIL idle_after_reset got rdy=%b rd_n=%b required 1 1", rdy, ram_read_n); end
  endtask

  task automatic test_cpu_read;
    bit ok; int t; int s;
    mem[17'h01234] = 8'hA5;
    exp_acc.push_back('{1'b0, 17'h01234, 8'h00});
    cpu_address = 20'h01234; cpu_memr_n = 1'b0;
    @(negedge clock);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL rd_rdy_fall got %b required 0", rdy); end
    wait_rdy(1'b1, 100, ok, t);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rd_timeout got rdy=%b required 1", rdy); end
    else begin
      s = recover_cyc;
      while (s % 3 != 0) s++;
      n_cmp++; if (t != s + 1) begin n_bad++; $display("FAIL rd_rdy_release got cycle %0d required %0d", t, s + 1); end
      n_cmp++; if (cpu_data_out !== 8'hA5) begin n_bad++; $display("FAIL rd_data got %h required A5", cpu_data_out); end
    end
    cpu_memr_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_cpu_write;
    bit ok; int t;
    exp_acc.push_back('{1'b1, 17'h00010, 8'h3C});
    cpu_address = 20'h00010; cpu_data_in = 8'h3C; cpu_memw_n = 1'b0;
    wait_rdy(1'b1, 100, ok, t);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_timeout got rdy=%b required 1", rdy); end
    n_cmp++; if (mem[17'h00010] !== 8'h3C) begin n_bad++; $display("FAIL wr_mem got %h required 3C", mem[17'h00010]); end
    n_cmp++; if (cpu_data_out !== 8'hA5) begin n_bad++; $display("FAIL wr_keeps_cdata got %h required A5", cpu_data_out); end
    cpu_memw_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_out_of_range;
    int a0 = n_acc;
    int low = 0;
    cpu_address = 20'h20000; cpu_memr_n = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (rdy !== 1'b1) low++;
    end
    n_cmp++; if (low != 0) begin n_bad++; $display("FAIL oor_rdy got %0d low cycles required 0", low); end
    n_cmp++; if (n_acc != a0) begin n_bad++; $display("FAIL oor_access got %0d accesses required 0", n_acc - a0); end
    cpu_memr_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_priority_same_cycle;
    exp_acc.push_back('{1'b0, 17'h02000, 8'h00});
    exp_acc.push_back('{1'b0, 17'h00400, 8'h00});
    exp_vid.push_back(mem[17'h02000]);
    cpu_address = 20'h00400; cpu_memr_n = 1'b0;
    fork
      video_run(1, 17'h02000);
      begin
        bit ok; int t;
        wait_rdy(1'b1, 200, ok, t);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL pri_timeout got rdy=%b required 1", rdy); end
        n_cmp++; if (cpu_data_out !== mem[17'h00400]) begin n_bad++; $display("FAIL pri_cdata got %h required %h", cpu_data_out, mem[17'h00400]); end
      end
    join
    cpu_memr_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_load;
    for (int k = 0; k < 4; k++) exp_vid.push_back(mem[17'h03000 + AW'(k)]);
`ifdef KFPCJR_FAIR_ARBITRATION_EN
    exp_acc.push_back('{1'b0, 17'h03000, 8'h00});
    exp_acc.push_back('{1'b0, 17'h00500, 8'h00});
    for (int k = 1; k < 4; k++) exp_acc.push_back('{1'b0, 17'h03000 + AW'(k), 8'h00});
`else
    for (int k = 0; k < 4; k++) exp_acc.push_back('{1'b0, 17'h03000 + AW'(k), 8'h00});
    exp_acc.push_back('{1'b0, 17'h00500, 8'h00});
`endif
    fork
      video_run(4, 17'h03000);
      begin
        bit ok; int t;
        wait_strobe(50, ok);
        cpu_address = 20'h00500; cpu_memr_n = 1'b0;
        wait_rdy(1'b1, 300, ok, t);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL load_timeout got rdy=%b required 1", rdy); end
        n_cmp++; if (cpu_data_out !== mem[17'h00500]) begin n_bad++; $display("FAIL load_cdata got %h required %h", cpu_data_out, mem[17'h00500]); end
      end
    join
    cpu_memr_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_once;
    bit ok; int t; int low = 0;
    int a0 = n_acc;
    exp_acc.push_back('{1'b0, 17'h00600, 8'h00});
    cpu_address = 20'h00600; cpu_memr_n = 1'b0;
    wait_rdy(1'b1, 100, ok, t);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL once_timeout got rdy=%b required 1", rdy); end
    repeat (20) begin
      @(negedge clock);
      if (rdy !== 1'b1) low++;
    end
    n_cmp++; if (n_acc - a0 != 1) begin n_bad++; $display("FAIL once_count got %0d accesses required 1", n_acc - a0); end
    n_cmp++; if (low != 0) begin n_bad++; $display("FAIL once_rdy got %0d low cycles required 0", low); end
    cpu_memr_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_access;
    bit ok; int t; int acks = 0;
    exp_acc.push_back('{1'b0, 17'h04000, 8'h00});
    video_address = 17'h04000; video_request = 1'b1;
    wait_strobe(50, ok);
    #2;
    reset = 1'b1; video_request = 1'b0;
    @(negedge clock);
    n_cmp++; if (ram_read_n !== 1'b1 || ram_write_n !== 1'b1) begin n_bad++; $display("FAIL mid_strobes got %b%b required 11", ram_read_n, ram_write_n); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rdy got %b required 1", rdy); end
    n_cmp++; if (cpu_data_out !== 8'h00) begin n_bad++; $display("FAIL mid_cdata got %h required 00", cpu_data_out); end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (video_ack === 1'b1) acks++;
    end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL mid_no_ack got %0d acks required 0", acks); end
    exp_acc.push_back('{1'b0, 17'h04001, 8'h00});
    exp_vid.push_back(mem[17'h04001]);
    video_run(1, 17'h04001);
    exp_acc.push_back('{1'b0, 17'h00700, 8'h00});
    cpu_address = 20'h00700; cpu_memr_n = 1'b0;
    wait_rdy(1'b1, 100, ok, t);
    n_cmp++; if (!ok || cpu_data_out !== mem[17'h00700]) begin n_bad++; $display("FAIL post_reset_read got %h required %h", cpu_data_out, mem[17'h00700]); end
    cpu_memr_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1; cpu_address = '0; cpu_data_in = '0;
    cpu_memr_n = 1'b1; cpu_memw_n = 1'b1;
    video_request = 1'b0; video_address = '0;
    @(negedge clock);
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_out_of_range();
    test_priority_same_cycle();
    test_load();
    test_once();
    test_reset_mid_access();
    n_cmp++;
    if (exp_acc.size() != 0 || exp_vid.size() != 0) begin
      n_bad++;
      $display("FAIL leftover got %0d/%0d pending required 0/0", exp_acc.size(), exp_vid.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
